// File: rtl/q_measure2_pkg.sv
// q_pkg: shared types and constants for the two-qubit measurement stage.
//   state_t      - measurement FSM states (IDLE, ACC, DRAW, SEL, DONE)
//   W_DEF        - default signed amplitude width (FIXED_WIDTH, 16 if undefined)
//   Q_ONE        - fixed-point 1.0 for the default fractional width
//   LFSR_TAPS    - Galois feedback taps of the 16-bit threshold LFSR
//   sq_width()   - width of re^2 + im^2 before the fractional shift
//   cum_width()  - width of the cumulative probability accumulator
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

package q_pkg;

  localparam int          W_DEF     = `FIXED_WIDTH;
  localparam int          F_DEF     = 8;
  localparam int          Q_ONE     = 1 << F_DEF;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    DRAW,
    SEL,
    DONE
  } state_t;

  // Sum of two full-width squares needs one extra bit.
  function automatic int sq_width(input int w);
    return 2 * w + 1;
  endfunction

  // Four accumulated probabilities need two more bits on top of that.
  function automatic int cum_width(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/q_measure2_if.sv
// q_measure2_if: amplitude input and result output handshakes of q_measure2.
//   in_valid/in_ready     - amplitude set handshake (upstream -> block)
//   in_real_xx/in_imag_xx - signed amplitudes of |00>,|01>,|10>,|11>
//   out_valid/out_ready   - result handshake (block -> downstream)
//   out_index/out_prob    - collapsed basis index and its saturated probability
//   out_err               - total probability was zero
// Modports: master drives amplitudes and out_ready, slave is the measurement block.
interface q_measure2_if #(
  parameter int W = q_pkg::W_DEF
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_real_00, in_imag_00;
  logic signed [W-1:0] in_real_01, in_imag_01;
  logic signed [W-1:0] in_real_10, in_imag_10;
  logic signed [W-1:0] in_real_11, in_imag_11;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_index;
  logic [W-1:0]        out_prob;
  logic                out_err;

  modport master (
    output in_valid, in_real_00, in_imag_00, in_real_01, in_imag_01,
           in_real_10, in_imag_10, in_real_11, in_imag_11, out_ready,
    input  in_ready, out_valid, out_index, out_prob, out_err
  );

  modport slave (
    input  in_valid, in_real_00, in_imag_00, in_real_01, in_imag_01,
           in_real_10, in_imag_10, in_real_11, in_imag_11, out_ready,
    output in_ready, out_valid, out_index, out_prob, out_err
  );
endinterface

// File: rtl/q_measure2_lfsr.sv
// q_lfsr16: 16-bit Galois LFSR supplying the measurement threshold.
//   clk, rst_n - clock, asynchronous active-low reset (loads SEED)
//   load       - load seed (a zero seed becomes 1 so the register never locks up)
//   seed       - seed value
//   step       - advance one step (taps LFSR_TAPS)
//   value      - current register contents
module q_lfsr16
  import q_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);
  localparam logic [15:0] RST_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= RST_VAL;
    else        value_q <= value_d;
  end

  assign value = value_q;
endmodule

// File: rtl/q_measure2.sv
// q_measure2: two-qubit computational-basis measurement.
//   clk, rst_n - clock, asynchronous active-low reset
//   seed_load  - load seed into the threshold LFSR (IDLE only)
//   seed       - LFSR seed
//   bus        - q_measure2_if.slave: amplitude input and result output handshakes
// Born probabilities are accumulated serially through one squaring path, a
// threshold r = (lfsr * total) >> 16 is drawn, and the first basis state whose
// cumulative probability exceeds r is reported.
module q_measure2
  import q_pkg::*;
#(
  parameter int          W         = W_DEF,
  parameter int          F         = F_DEF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  q_measure2_if.slave bus
);
  localparam int W2    = 2 * W;
  localparam int SQ_W  = sq_width(W);
  localparam int CUM_W = cum_width(W);
  localparam int PRD_W = CUM_W + 16;

  state_t                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic signed [W-1:0]    re_q [4];
  logic signed [W-1:0]    im_q [4];
  logic [CUM_W-1:0]       cum_q [4];
  logic [CUM_W-1:0]       r_q;
  logic [1:0]             idx_q;
  logic [W-1:0]           prob_q;
  logic                   err_q;
  logic [15:0]            lfsr_val;
  logic                   accept;

  logic signed [W2-1:0]   re_sq, im_sq;
  logic [SQ_W-1:0]        sq_sum;
  logic [CUM_W-1:0]       p_k, cum_prev;
  logic [PRD_W-1:0]       draw_prod;
  logic [1:0]             sel_idx;
  logic                   sel_found;
  logic [CUM_W-1:0]       sel_p;
  logic                   total_zero;

  function automatic logic [W-1:0] sat_prob(input logic [CUM_W-1:0] v);
    if (v > CUM_W'({W{1'b1}})) return {W{1'b1}};
    return v[W-1:0];
  endfunction

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_index = idx_q;
  assign bus.out_prob  = prob_q;
  assign bus.out_err   = err_q;

  q_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  ((state_q == IDLE) && seed_load),
    .seed  (seed),
    .step  (state_q == DRAW),
    .value (lfsr_val)
  );

  // Squares are kept at full 2W precision; the shift happens only after the sum.
  always_comb begin
    re_sq    = W2'(re_q[k_q]) * W2'(re_q[k_q]);
    im_sq    = W2'(im_q[k_q]) * W2'(im_q[k_q]);
    sq_sum   = SQ_W'($unsigned(re_sq)) + SQ_W'($unsigned(im_sq));
    p_k      = CUM_W'(sq_sum >> F);
    cum_prev = (k_q == 2'd0) ? '0 : cum_q[k_q - 2'd1];
  end

  // r < total whenever total > 0 because lfsr < 2^16.
  assign draw_prod  = PRD_W'(lfsr_val) * PRD_W'(cum_q[3]);
  assign total_zero = (cum_q[3] == '0);

  always_comb begin
    sel_idx   = 2'd3;
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sel_found && (r_q < cum_q[i])) begin
        sel_idx   = 2'(i);
        sel_found = 1'b1;
      end
    end
    // Individual probability recovered from adjacent cumulative sums.
    sel_p = cum_q[sel_idx] - ((sel_idx == 2'd0) ? '0 : cum_q[sel_idx - 2'd1]);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = ACC;
        k_d     = 2'd0;
      end
      ACC: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = DRAW;
      end
      DRAW: state_d = SEL;
      SEL:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        re_q[i]  <= '0;
        im_q[i]  <= '0;
        cum_q[i] <= '0;
      end
      r_q    <= '0;
      idx_q  <= 2'd0;
      prob_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      re_q[0] <= bus.in_real_00;  im_q[0] <= bus.in_imag_00;
      re_q[1] <= bus.in_real_01;  im_q[1] <= bus.in_imag_01;
      re_q[2] <= bus.in_real_10;  im_q[2] <= bus.in_imag_10;
      re_q[3] <= bus.in_real_11;  im_q[3] <= bus.in_imag_11;
      for (int i = 0; i < 4; i++) cum_q[i] <= '0;
      err_q <= 1'b0;
    end else if (state_q == ACC) begin
      cum_q[k_q] <= cum_prev + p_k;
    end else if (state_q == DRAW) begin
      r_q <= CUM_W'(draw_prod >> 16);
    end else if (state_q == SEL) begin
      idx_q  <= total_zero ? 2'd0 : sel_idx;
      prob_q <= total_zero ? '0 : sat_prob(sel_p);
      err_q  <= total_zero;
    end
  end
endmodule

// File: doc/q_measure2.md
Name: q_measure2

Overview:
- Two-qubit computational-basis measurement stage. Sits directly downstream of q_cnot and consumes its four complex amplitudes (|00>,|01>,|10>,|11>).
- Computes the Born probabilities serially with one squaring datapath and draws a pseudo-random threshold from an internal LFSR.
- Reports the collapsed basis index and its probability through a valid/ready handshake.
- Input and output handshakes are both valid/ready, so the block can be chained into the readout path.

Parameters:
W, `FIXED_WIDTH (16), signed amplitude width.
F, 8, fractional bits of the fixed-point format; 1.0 = 2^F.
LFSR_SEED, 16'hACE1, reset value of the LFSR; a value of 0 is replaced by 16'h0001.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  amplitude set valid.
in_ready  out  1  block can accept a set.
in_real_00, in_imag_00, in_real_01, in_imag_01, in_real_10, in_imag_10, in_real_11, in_imag_11  in  W each  signed amplitudes (q_cnot output order).
seed_load  in  1  load seed into LFSR; honoured only in IDLE.
seed  in  16  LFSR seed value (0 is replaced by 1).
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_index  out  2  measured basis state (0=|00> ... 3=|11>).
out_prob  out  W  unsigned probability of the measured state, saturated to W bits.
out_err  out  1  total probability was zero; the result is invalid.

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0:
  - FSM returns to IDLE.
  - in_ready=0 while reset is asserted, then 1 in IDLE.
  - out_valid=0, out_index=0, out_prob=0, out_err=0.
  - All accumulators are cleared and the LFSR is set to LFSR_SEED.
  - Reset mid-operation abandons the measurement; no partial result is emitted.
- FSM states: IDLE -> ACC -> DRAW -> SEL -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register all 8 amplitudes, clear the sum, set k=0 and go to ACC.
  - If seed_load is high in the same cycle, load the seed in that cycle.
- ACC (4 cycles, k=0..3):
  - p_k = (re_k^2 + im_k^2) >> F. Products are formed at full 2W width and the sum at 2W+1 bits, so nothing overflows before the shift.
  - cum_k = cum_{k-1} + p_k, width 2W+3, unsigned.
  - After k=3, total = cum_3; go to DRAW.
- DRAW (1 cycle):
  - r = (lfsr * total) >> 16, which guarantees r < total when total > 0.
  - Uses the LFSR value present in that cycle.
  - The LFSR then advances one step: Galois, taps 16'hB400, never 0.
- SEL (1 cycle):
  - out_index = the smallest k with r < cum_k.
  - out_prob = p_k saturated to 2^W-1.
  - If total==0: out_index=0, out_prob=0, out_err=1.
  - Go to DONE.
- DONE:
  - out_valid=1. Outputs are stable and held until out_ready=1.
  - On out_valid&&out_ready go to IDLE. out_valid drops and in_ready rises in the next cycle.
  - out_err is cleared on the next accepted input.
- Latency: accept at cycle T; ACC runs T+1..T+4, DRAW T+5, SEL T+6; out_valid=1 from T+7.
- Throughput: one measurement per 8 cycles with no backpressure. No overlap: in_ready=0 outside IDLE.
- seed_load outside IDLE is ignored. The LFSR advances only in DRAW.
- Amplitude sign is irrelevant, because only squares are used.
- Amplitudes of unnormalized states are handled correctly, because the threshold scales with total.

Decomposition:
- Package q_pkg holds:
  - the FSM state enum (IDLE, ACC, DRAW, SEL, DONE);
  - Q_ONE = 1<<F;
  - LFSR_TAPS = 16'hB400;
  - the probability/cumulative width localparams.
- Sub-module q_lfsr16 holds the LFSR, with ports clk, rst_n, load, seed, step, value.
- The squaring and accumulation stay inline. q_mul is not used here, because it truncates and the squares need full precision.

Test Plan:
- Basis state: in_real_00=256, all others 0, any seed -> p0=256, total=256, out_index=0, out_prob=256, out_err=0, out_valid at T+7.
- Bell state, low seed: in_real_00=181, in_real_11=181, seed_load with seed=16'h0001 -> p0=p3=127, total=254, r=0, out_index=0, out_prob=127.
- Bell state, high seed: same input, seed=16'hFFFF -> r=253, cum=127,127,127,254, out_index=3, out_prob=127.
- Negative and imaginary amplitudes: in_real_10=-256 -> out_index=2, out_prob=256. Separately, in_imag_01=-256 -> out_index=1.
- Zero state: all amplitudes 0 -> out_err=1, out_index=0, out_prob=0. A following valid input clears out_err.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles -> out_valid, out_index and out_prob are stable, and in_ready=0 throughout.
  - Assert rst_n=0 in ACC cycle 2 -> outputs go to reset values immediately; in_ready=1 after release, and no stale result is emitted.
